// File: rtl/ps2_mouse_sequencer.sv
// ps2_mouse_sequencer
//
// Drives a PS/2 mouse through its power-up dialogue (reset, self-test,
// optional sample-rate set, enable streaming), restarting the dialogue on a
// NAK, a wrong byte or a silent mouse. Once streaming, it frames incoming
// bytes into 3-byte movement packets for the position tracker.
//
// Optional feature macro: PS2_MOUSE_SAMPLE_RATE_EN
//   When defined, 0xF3 <SAMPLE_RATE> is sent between the ID byte and enable.
//
// Ports
//   clock                          system clock (shared with PS/2 controller)
//   reset                          asynchronous active-low reset
//   reinit                         synchronous restart of the dialogue
//   the_command[7:0]               command byte for the PS/2 controller
//   send_command                   request, held until sent or failed
//   command_was_sent               controller pulse: byte transmitted
//   error_communication_timed_out  controller pulse: transmit failed
//   received_data[7:0]             byte from the mouse
//   received_data_en               strobe: received_data valid
//   pkt_byte1..3[7:0]              last complete movement packet
//   pkt_valid                      one-cycle strobe on a new packet
//   init_done                      high while streaming
//   init_failed                    high once retries are exhausted
//   retry_count[2:0]               restarts used in the current attempt
module ps2_mouse_sequencer #(
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000_000,
  parameter logic [2:0]  MAX_RETRIES    = 3'd3,
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reinit,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] pkt_byte1,
  output logic [7:0] pkt_byte2,
  output logic [7:0] pkt_byte3,
  output logic       pkt_valid,
  output logic       init_done,
  output logic       init_failed,
  output logic [2:0] retry_count
);

  typedef enum logic [3:0] {
    SEND_RESET        = 4'd0,
    WAIT_RESET_ACK    = 4'd1,
    WAIT_BAT          = 4'd2,
    WAIT_ID           = 4'd3,
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
    SEND_RATE_CMD     = 4'd4,
    WAIT_RATE_CMD_ACK = 4'd5,
    SEND_RATE_ARG     = 4'd6,
    WAIT_RATE_ARG_ACK = 4'd7,
`endif
    SEND_ENABLE       = 4'd8,
    WAIT_ENABLE_ACK   = 4'd9,
    STREAM            = 4'd10,
    FAILED            = 4'd11
  } state_t;

  localparam logic [25:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 26'd1;

  state_t      state_r;
  logic [25:0] timer_r;
  logic [1:0]  idx_r;
  logic [7:0]  shadow1_r;
  logic [7:0]  shadow2_r;

  logic   state_is_send_s;
  logic   state_is_wait_s;
  logic   timer_expired_s;
  logic   byte_ok_s;
  logic   fault_s;
  logic   ack_s;
  logic   retry_left_s;
  state_t next_s;

`ifndef PS2_MOUSE_SAMPLE_RATE_EN
  // The rate argument only matters when the rate dialogue is built in.
  logic unused_rate_s;
  assign unused_rate_s = ^SAMPLE_RATE;
`endif

  function automatic logic is_send(input state_t s);
    case (s)
      SEND_RESET, SEND_ENABLE: is_send = 1'b1;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      SEND_RATE_CMD, SEND_RATE_ARG: is_send = 1'b1;
`endif
      default: is_send = 1'b0;
    endcase
  endfunction

  function automatic logic is_wait(input state_t s);
    case (s)
      WAIT_RESET_ACK, WAIT_BAT, WAIT_ID, WAIT_ENABLE_ACK: is_wait = 1'b1;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      WAIT_RATE_CMD_ACK, WAIT_RATE_ARG_ACK: is_wait = 1'b1;
`endif
      default: is_wait = 1'b0;
    endcase
  endfunction

  // Byte the mouse must answer with in a given wait state.
  function automatic logic [7:0] expected_byte(input state_t s);
    case (s)
      WAIT_BAT: expected_byte = 8'hAA;
      WAIT_ID:  expected_byte = 8'h00;
      default:  expected_byte = 8'hFA;
    endcase
  endfunction

  function automatic logic [7:0] command_for(input state_t s);
    case (s)
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      SEND_RATE_CMD: command_for = 8'hF3;
      SEND_RATE_ARG: command_for = SAMPLE_RATE;
`endif
      SEND_ENABLE:   command_for = 8'hF4;
      default:       command_for = 8'hFF;
    endcase
  endfunction

  // Successor along the nominal dialogue.
  function automatic state_t next_state(input state_t s);
    case (s)
      SEND_RESET:        next_state = WAIT_RESET_ACK;
      WAIT_RESET_ACK:    next_state = WAIT_BAT;
      WAIT_BAT:          next_state = WAIT_ID;
`ifdef PS2_MOUSE_SAMPLE_RATE_EN
      WAIT_ID:           next_state = SEND_RATE_CMD;
      SEND_RATE_CMD:     next_state = WAIT_RATE_CMD_ACK;
      WAIT_RATE_CMD_ACK: next_state = SEND_RATE_ARG;
      SEND_RATE_ARG:     next_state = WAIT_RATE_ARG_ACK;
      WAIT_RATE_ARG_ACK: next_state = SEND_ENABLE;
`else
      WAIT_ID:           next_state = SEND_ENABLE;
`endif
      SEND_ENABLE:       next_state = WAIT_ENABLE_ACK;
      WAIT_ENABLE_ACK:   next_state = STREAM;
      default:           next_state = SEND_RESET;
    endcase
  endfunction

  // Classify the current cycle: dialogue step accepted, fault, or neither.
  always_comb begin
    state_is_send_s = is_send(state_r);
    state_is_wait_s = is_wait(state_r);
    timer_expired_s = (timer_r == TIMEOUT_LAST);
    byte_ok_s       = (received_data == expected_byte(state_r));
    retry_left_s    = (retry_count < MAX_RETRIES);
    next_s          = next_state(state_r);
    fault_s         = 1'b0;
    ack_s           = 1'b0;
    if (state_is_send_s) begin
      // A successful send wins over a simultaneous transmit error.
      fault_s = error_communication_timed_out && !command_was_sent;
    end else if (state_is_wait_s) begin
      if (received_data_en) begin
        fault_s = !byte_ok_s;
        ack_s   = byte_ok_s;
      end else begin
        fault_s = timer_expired_s;
      end
    end else begin
      fault_s = 1'b0;
    end
  end

  // Sequencer state, command handshake, retry bookkeeping and packet framing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= SEND_RESET;
      the_command  <= 8'hFF;
      send_command <= 1'b0;
      timer_r      <= 26'd0;
      idx_r        <= 2'd0;
      shadow1_r    <= 8'h00;
      shadow2_r    <= 8'h00;
      pkt_byte1    <= 8'h00;
      pkt_byte2    <= 8'h00;
      pkt_byte3    <= 8'h00;
      pkt_valid    <= 1'b0;
      init_done    <= 1'b0;
      init_failed  <= 1'b0;
      retry_count  <= 3'd0;
    end else begin
      pkt_valid <= 1'b0;
      if (reinit) begin
        // Restart takes priority over anything arriving this cycle.
        state_r      <= SEND_RESET;
        the_command  <= 8'hFF;
        send_command <= 1'b1;
        timer_r      <= 26'd0;
        idx_r        <= 2'd0;
        init_done    <= 1'b0;
        init_failed  <= 1'b0;
        retry_count  <= 3'd0;
      end else if (fault_s) begin
        timer_r <= 26'd0;
        if (retry_left_s) begin
          retry_count  <= retry_count + 3'd1;
          state_r      <= SEND_RESET;
          the_command  <= 8'hFF;
          send_command <= 1'b1;
        end else begin
          state_r      <= FAILED;
          init_failed  <= 1'b1;
          send_command <= 1'b0;
        end
      end else if (state_is_send_s) begin
        timer_r <= 26'd0;
        if (command_was_sent) begin
          send_command <= 1'b0;
          state_r      <= next_s;
        end else begin
          send_command <= 1'b1;
        end
      end else if (state_is_wait_s) begin
        if (ack_s) begin
          timer_r <= 26'd0;
          state_r <= next_s;
          if (next_s == STREAM) begin
            init_done <= 1'b1;
          end else if (is_send(next_s)) begin
            the_command  <= command_for(next_s);
            send_command <= 1'b1;
          end else begin
            send_command <= 1'b0;
          end
        end else begin
          timer_r <= timer_r + 26'd1;
        end
      end else begin
        case (state_r)
          STREAM: begin
            init_done    <= 1'b1;
            send_command <= 1'b0;
            if (received_data_en) begin
              timer_r <= 26'd0;
              case (idx_r)
                // First byte must carry the always-one sync bit.
                2'd0: begin
                  if (received_data[3]) begin
                    shadow1_r <= received_data;
                    idx_r     <= 2'd1;
                  end else begin
                    idx_r <= 2'd0;
                  end
                end
                2'd1: begin
                  shadow2_r <= received_data;
                  idx_r     <= 2'd2;
                end
                2'd2: begin
                  pkt_byte1 <= shadow1_r;
                  pkt_byte2 <= shadow2_r;
                  pkt_byte3 <= received_data;
                  pkt_valid <= 1'b1;
                  idx_r     <= 2'd0;
                end
                default: idx_r <= 2'd0;
              endcase
            end else if (idx_r != 2'd0) begin
              // A stalled partial packet is abandoned.
              if (timer_expired_s) begin
                idx_r   <= 2'd0;
                timer_r <= 26'd0;
              end else begin
                timer_r <= timer_r + 26'd1;
              end
            end else begin
              timer_r <= 26'd0;
            end
          end
          FAILED: begin
            send_command <= 1'b0;
            init_failed  <= 1'b1;
            init_done    <= 1'b0;
            timer_r      <= 26'd0;
          end
          default: begin
            state_r      <= SEND_RESET;
            the_command  <= 8'hFF;
            send_command <= 1'b1;
            timer_r      <= 26'd0;
          end
        endcase
      end
    end
  end

endmodule
